// File: rtl/hazard_stall_unit_if.sv
// Decode/execute hazard handshake between the pipeline and the hazard stall unit.
// Master drives the pipeline-side inputs; the slave (stall unit) returns the stall/flush controls.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instruction_fd;
    logic [31:0]      instruction_de;
    logic             RegDst_de;
    logic             mem_read_de;
    logic             reg_w_ctl_de;
    logic             branch_taken;
    logic             cnt_clear;
    logic             stall_ctl;
    logic             pc_write_en;
    logic             fd_write_en;
    logic             fd_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output instruction_fd, instruction_de, RegDst_de, mem_read_de,
               reg_w_ctl_de, branch_taken, cnt_clear,
        input  stall_ctl, pc_write_en, fd_write_en, fd_flush,
               stall_cycles, flush_events
    );

    modport slave (
        input  instruction_fd, instruction_de, RegDst_de, mem_read_de,
               reg_w_ctl_de, branch_taken, cnt_clear,
        output stall_ctl, pc_write_en, fd_write_en, fd_flush,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection and taken-branch flush control for the F/D and D/E pipeline registers.
// state | meaning
// RUN   | normal issue; stalls for one cycle on a load-use hazard, flushes on a taken branch
// STALL | extra load-use stall cycles still owed; a taken branch aborts the stall
module hazard_stall_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    hazard_stall_unit_if.slave  bus
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0]       STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t           state;
    logic [1:0]       remaining;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest_de;
    logic       uses_rt;
    logic       hazard;
    logic       do_flush;
    logic       do_stall;
    logic       unused_bits;

    always_comb begin
        opcode  = bus.instruction_fd[31:26];
        rs      = bus.instruction_fd[25:21];
        rt      = bus.instruction_fd[20:16];
        uses_rt = (opcode == 6'h00) || (opcode == 6'h2B) ||
                  (opcode == 6'h04) || (opcode == 6'h05);
        dest_de = bus.RegDst_de ? bus.instruction_de[15:11] : bus.instruction_de[20:16];
        // $0 is hardwired, so a load targeting it can never create a dependency
        hazard  = bus.mem_read_de && bus.reg_w_ctl_de && (dest_de != 5'd0) &&
                  ((dest_de == rs) || (uses_rt && (dest_de == rt)));
    end

    // A taken branch wins in both states; an owed stall ignores the live hazard
    // because the load has already left execute.
    always_comb begin
        do_flush = bus.branch_taken;
        do_stall = !bus.branch_taken && ((state == STALL) || hazard);
    end

    assign bus.stall_ctl    = do_flush || do_stall;
    assign bus.pc_write_en  = !do_stall;
    assign bus.fd_write_en  = !do_stall;
    assign bus.fd_flush     = do_flush;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;

    assign unused_bits = ^{bus.instruction_fd[15:0], bus.instruction_de[31:21],
                           bus.instruction_de[10:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            remaining <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.branch_taken && hazard && (LOAD_STALL_CYCLES > 1)) begin
                        remaining <= STALL_RELOAD;
                        state     <= STALL;
                    end
                end
                STALL: begin
                    if (bus.branch_taken) begin
                        remaining <= 2'd0;
                        state     <= RUN;
                    end else begin
                        remaining <= remaining - 2'd1;
                        if (remaining == 2'd1) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    remaining <= 2'd0;
                    state     <= RUN;
                end
            endcase
        end
    end

    // Clear has priority over a same-cycle increment; both counters saturate.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (bus.cnt_clear) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (do_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: four instances (1/2/3 stall cycles, narrow counter)
// share one stimulus stream; each step checks the instance it targets.
module tb_hazard_stall_unit;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    hazard_stall_unit_if #(.CNT_W(16)) if1 ();
    hazard_stall_unit_if #(.CNT_W(16)) if2 ();
    hazard_stall_unit_if #(.CNT_W(16)) if3 ();
    hazard_stall_unit_if #(.CNT_W(4))  if4 ();

    hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1.slave));
    hazard_stall_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(16)) u2 (.clock(clock), .reset_n(reset_n), .bus(if2.slave));
    hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (.clock(clock), .reset_n(reset_n), .bus(if3.slave));
    hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4))  u4 (.clock(clock), .reset_n(reset_n), .bus(if4.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {stall_ctl, pc_write_en, fd_write_en, fd_flush}
    localparam logic [3:0] IDLE  = 4'b0110;
    localparam logic [3:0] STALL = 4'b1000;
    localparam logic [3:0] FLUSH = 4'b1111;

    localparam logic [31:0] LW_R8    = {6'h23, 5'd0, 5'd8, 16'h0004};
    localparam logic [31:0] LW_R0    = {6'h23, 5'd0, 5'd0, 16'h0004};
    localparam logic [31:0] ADD_9_8_3 = {6'h00, 5'd8, 5'd3, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] ADD_9_0_0 = {6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] ADDI_8_3 = {6'h08, 5'd3, 5'd8, 16'h0005};
    localparam logic [31:0] SW_8_3   = {6'h2B, 5'd3, 5'd8, 16'h0000};
    localparam logic [31:0] RTYPE_D8 = {6'h00, 5'd1, 5'd5, 5'd8, 5'd0, 6'h20};
    localparam logic [31:0] NOP      = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] fd, input logic [31:0] de, input logic regdst,
                         input logic mr, input logic rw, input logic br, input logic clr);
        if1.instruction_fd = fd; if1.instruction_de = de; if1.RegDst_de = regdst;
        if1.mem_read_de = mr; if1.reg_w_ctl_de = rw; if1.branch_taken = br; if1.cnt_clear = clr;
        if2.instruction_fd = fd; if2.instruction_de = de; if2.RegDst_de = regdst;
        if2.mem_read_de = mr; if2.reg_w_ctl_de = rw; if2.branch_taken = br; if2.cnt_clear = clr;
        if3.instruction_fd = fd; if3.instruction_de = de; if3.RegDst_de = regdst;
        if3.mem_read_de = mr; if3.reg_w_ctl_de = rw; if3.branch_taken = br; if3.cnt_clear = clr;
        if4.instruction_fd = fd; if4.instruction_de = de; if4.RegDst_de = regdst;
        if4.mem_read_de = mr; if4.reg_w_ctl_de = rw; if4.branch_taken = br; if4.cnt_clear = clr;
    endtask

    task automatic neutral();
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        neutral();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        neutral();
        #2;
        check("reset ctl", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, IDLE);
        check("reset stall_cycles", if1.stall_cycles, 16'h0);
        check("reset flush_events", if1.flush_events, 16'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: single-cycle load-use stall
        @(negedge clock);
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("t1 stall", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, STALL);
        @(negedge clock);
        neutral();
        #1 check("t1 release", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, IDLE);
        check("t1 stall_cycles", if1.stall_cycles, 16'd1);
        check("t1 lsc2 owes stall", {if2.stall_ctl, if2.pc_write_en, if2.fd_write_en, if2.fd_flush}, STALL);

        // 2: non-hazards and the other hazard forms
        do_reset();
        drive(ADD_9_0_0, LW_R0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("t2 dest r0", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, IDLE);
        drive(ADDI_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("t2 addi rt", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, IDLE);
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("t2 no regwrite", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, IDLE);
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("t2 not load", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, IDLE);
        drive(SW_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("t2 sw rt", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, STALL);
        drive(ADD_9_8_3, RTYPE_D8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("t2 regdst rd", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, STALL);
        drive(ADD_9_8_3, RTYPE_D8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("t2 regdst rt", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, IDLE);
        neutral();

        // 3: two-cycle stall
        do_reset();
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("t3 cycle1", {if2.stall_ctl, if2.pc_write_en, if2.fd_write_en, if2.fd_flush}, STALL);
        @(negedge clock);
        neutral();
        #1 check("t3 cycle2", {if2.stall_ctl, if2.pc_write_en, if2.fd_write_en, if2.fd_flush}, STALL);
        @(negedge clock);
        #1 check("t3 run", {if2.stall_ctl, if2.pc_write_en, if2.fd_write_en, if2.fd_flush}, IDLE);
        check("t3 stall_cycles", if2.stall_cycles, 16'd2);

        // 4: branch beats hazard
        do_reset();
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 check("t4 flush", {if1.stall_ctl, if1.pc_write_en, if1.fd_write_en, if1.fd_flush}, FLUSH);
        @(negedge clock);
        neutral();
        #1 check("t4 flush_events", if1.flush_events, 16'd1);
        check("t4 stall_cycles", if1.stall_cycles, 16'd0);

        // 5: branch aborts a three-cycle stall in its second cycle
        do_reset();
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("t5 cycle1", {if3.stall_ctl, if3.pc_write_en, if3.fd_write_en, if3.fd_flush}, STALL);
        @(negedge clock);
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 check("t5 abort flush", {if3.stall_ctl, if3.pc_write_en, if3.fd_write_en, if3.fd_flush}, FLUSH);
        @(negedge clock);
        neutral();
        #1 check("t5 run", {if3.stall_ctl, if3.pc_write_en, if3.fd_write_en, if3.fd_flush}, IDLE);
        check("t5 stall_cycles", if3.stall_cycles, 16'd1);
        check("t5 flush_events", if3.flush_events, 16'd1);

        // 6: saturation on the 4-bit instance, clear beats increment
        do_reset();
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (17) @(posedge clock);
        #1 check("t6 saturate", if4.stall_cycles, 4'hF);
        @(negedge clock);
        #1 check("t6 hold max", if4.stall_cycles, 4'hF);
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clock);
        #1 check("t6 clear wins", if4.stall_cycles, 4'h0);

        // 6: reset during the first STALL cycle
        do_reset();
        drive(ADD_9_8_3, LW_R8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        neutral();
        #1 check("t6 in stall", {if2.stall_ctl, if2.pc_write_en, if2.fd_write_en, if2.fd_flush}, STALL);
        reset_n = 1'b0;
        #1 check("t6 reset idle", {if2.stall_ctl, if2.pc_write_en, if2.fd_write_en, if2.fd_flush}, IDLE);
        check("t6 reset count", if2.stall_cycles, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1 check("t6 after reset", {if2.stall_ctl, if2.pc_write_en, if2.fd_write_en, if2.fd_flush}, IDLE);
        check("t6 after count", if2.stall_cycles, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
